// File: rtl/adc_fft_framer.sv
`default_nettype none
// ============================================================================
// Module   : adc_fft_framer
// Brief    : LTC2308 results -> signed Avalon-ST frames for the FFT sink.
// Revision : 1.0  initial release
// ============================================================================
module adc_fft_framer #(
    parameter int SAMPLE_W   = 12,
    parameter int OUT_W      = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                run,
    input  logic                mode,
    input  logic                arm,
    input  logic                clear_ovf,
    input  logic                src_ready,
    output logic                src_valid,
    output logic                src_sop,
    output logic                src_eop,
    output logic [OUT_W-1:0]    src_real,
    output logic [OUT_W-1:0]    src_imag,
    output logic [1:0]          src_error,
    output logic [CNT_W-1:0]    fftpts,
    output logic                ovf,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_FW = $clog2(FRAME_LEN);
    localparam logic [OUT_W-1:0] c_HALF     = OUT_W'(2 ** (SAMPLE_W - 1));
    localparam logic [c_AW:0]    c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_FW-1:0]  c_LAST     = c_FW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prev;
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [c_FW-1:0]   r_cap_cnt;
    logic [c_FW-1:0]   r_out_cnt;
    logic              r_ovf;
    logic [7:0]        r_drop_cnt;
    logic [OUT_W-1:0]  r_mem [FIFO_DEPTH];

    logic              w_edge;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_drop;
    logic              w_frame_end;
    logic [c_AW:0]     w_count;
    logic [OUT_W-1:0]  w_conv;

    assign w_edge  = adc_valid & ~r_prev;
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_DEPTH);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_rd_en = ~w_empty & src_ready;

    // Offset-binary to two's complement: modular subtraction in OUT_W bits
    // yields the sign-extended result because OUT_W > SAMPLE_W.
    assign w_conv = {{(OUT_W - SAMPLE_W){1'b0}}, adc_data} - c_HALF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_drop      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((!mode && run) || (mode && arm)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_edge) begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        // run/mode are only consulted here, so a frame in
                        // progress always completes.
                        if (r_cap_cnt == c_LAST) begin
                            w_frame_end = 1'b1;
                            if (!(!mode && run)) begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cap_cnt  <= '0;
            r_out_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_prev <= adc_valid;
            if (w_wr_en) begin
                r_wr_ptr  <= r_wr_ptr + (c_AW + 1)'(1);
                r_cap_cnt <= w_frame_end ? '0 : r_cap_cnt + c_FW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + (c_AW + 1)'(1);
                r_out_cnt <= r_out_cnt + c_FW'(1);
            end
            if (clear_ovf) begin
                r_ovf      <= w_drop;
                r_drop_cnt <= {7'd0, w_drop};
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // Sample storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_conv;
        end
    end

    assign src_valid = ~w_empty;
    assign src_real  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign src_sop   = src_valid & (r_out_cnt == '0);
    assign src_eop   = src_valid & (r_out_cnt == c_LAST);
    assign src_imag  = '0;
    assign src_error = 2'b00;
    assign fftpts    = CNT_W'(FRAME_LEN);
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = (r_state == S_CAPTURE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_adc_fft_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_fft_framer
// Brief    : Directed + randomized bench against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_fft_framer;

    localparam int c_FL    = 8;
    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        run;
    logic        mode;
    logic        arm;
    logic        clear_ovf;
    logic        src_ready;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic [15:0] src_real;
    logic [15:0] src_imag;
    logic [1:0]  src_error;
    logic [3:0]  fftpts;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        busy;

    adc_fft_framer #(
        .SAMPLE_W   (12),
        .OUT_W      (16),
        .FRAME_LEN  (c_FL),
        .FIFO_DEPTH (c_DEPTH),
        .CNT_W      (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .run       (run),
        .mode      (mode),
        .arm       (arm),
        .clear_ovf (clear_ovf),
        .src_ready (src_ready),
        .src_valid (src_valid),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .src_real  (src_real),
        .src_imag  (src_imag),
        .src_error (src_error),
        .fftpts    (fftpts),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: samples in flight, capture activity, beat index.
    int m_q[$];
    bit m_cap;
    int m_cnt;
    int m_out;
    bit m_ovf;
    int m_drop;
    bit m_prev;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs against the model, advance the model with the current
    // inputs, then move to the next falling edge.
    task automatic cycle();
        bit e;
        bit full;
        bit drop;
        bit was_cap;
        check("valid", int'(src_valid), int'(m_q.size() > 0));
        check("real", int'($signed(src_real)), (m_q.size() > 0) ? m_q[0] : 0);
        check("sop", int'(src_sop), int'(m_q.size() > 0 && m_out == 0));
        check("eop", int'(src_eop), int'(m_q.size() > 0 && m_out == c_FL - 1));
        check("ovf", int'(ovf), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drop);
        check("busy", int'(busy), int'(m_cap || m_q.size() > 0));
        check("imag", int'(src_imag), 0);
        check("error", int'(src_error), 0);
        check("fftpts", int'(fftpts), c_FL);
        if (reset) begin
            m_q.delete();
            m_cap  = 0;
            m_cnt  = 0;
            m_out  = 0;
            m_ovf  = 0;
            m_drop = 0;
            m_prev = 0;
        end else begin
            e       = adc_valid && !m_prev;
            m_prev  = adc_valid;
            full    = (m_q.size() == c_DEPTH);
            was_cap = m_cap;
            drop    = 0;
            if (m_q.size() > 0 && src_ready) begin
                void'(m_q.pop_front());
                m_out = (m_out + 1) % c_FL;
            end
            if (was_cap && e) begin
                if (full) begin
                    drop = 1;
                end else begin
                    m_q.push_back(int'(adc_data) - 2048);
                    m_cnt++;
                    if (m_cnt == c_FL) begin
                        m_cnt = 0;
                        m_cap = (!mode && run);
                    end
                end
            end else if (!was_cap) begin
                m_cap = (!mode && run) || (mode && arm);
            end
            if (clear_ovf) begin
                m_ovf  = drop;
                m_drop = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic edge_pulse(input int d);
        adc_data  = 12'(d);
        adc_valid = 1'b1;
        cycle();
        adc_valid = 1'b0;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset     = 1'b1;
        adc_data  = '0;
        adc_valid = 1'b0;
        run       = 1'b0;
        mode      = 1'b0;
        arm       = 1'b0;
        clear_ovf = 1'b0;
        src_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_q.delete();
        m_cap = 0; m_cnt = 0; m_out = 0; m_ovf = 0; m_drop = 0; m_prev = 0;
        idle(2);
        reset = 1'b0;
        idle(2);

        // Continuous capture, data 0..15 -> -2048..-2033, two frames.
        run = 1'b1;
        for (int i = 0; i < 16; i++) edge_pulse(i);
        run = 1'b0;
        idle(10);

        // Held-high flag yields a single sample; run re-enabled first.
        run = 1'b1;
        idle(1);
        adc_data  = 12'd4095;
        adc_valid = 1'b1;
        idle(10);
        adc_valid = 1'b0;
        for (int i = 0; i < 7; i++) edge_pulse(2048 + i);
        run = 1'b0;
        idle(10);

        // Single-shot: one frame then idle; extra edges ignored.
        mode = 1'b1;
        arm  = 1'b1;
        cycle();
        arm  = 1'b0;
        for (int i = 0; i < 20; i++) edge_pulse(100 + i * 37);
        idle(10);
        mode = 1'b0;

        // Backpressure on a 4-deep FIFO, then drain and clear.
        src_ready = 1'b0;
        run       = 1'b1;
        idle(1);
        for (int i = 0; i < 6; i++) edge_pulse(3000 + i);
        run = 1'b0;
        for (int i = 0; i < 2; i++) edge_pulse(500 + i);
        src_ready = 1'b1;
        idle(10);
        clear_ovf = 1'b1;
        cycle();
        clear_ovf = 1'b0;
        idle(2);

        // Reset after a few beats of a frame; next beat must carry sop.
        run = 1'b1;
        for (int i = 0; i < 5; i++) edge_pulse(1000 + i);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) edge_pulse(1200 + i);
        run = 1'b0;
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!adc_valid) adc_data = 12'($urandom_range(0, 4095));
            adc_valid = 1'($urandom_range(0, 1));
            src_ready = ($urandom_range(0, 3) != 0);
            run       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            arm       = ($urandom_range(0, 15) == 0);
            clear_ovf = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset     = 1'b0;
        arm       = 1'b0;
        clear_ovf = 1'b0;

        // Saturate drop_cnt with a stalled sink, then clear.
        mode      = 1'b0;
        run       = 1'b1;
        src_ready = 1'b0;
        for (int i = 0; i < 300; i++) edge_pulse(int'($urandom_range(0, 4095)));
        check("drop_sat", int'(drop_cnt), 255);
        clear_ovf = 1'b1;
        cycle();
        clear_ovf = 1'b0;
        run       = 1'b0;
        src_ready = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
